// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the slide-switch debouncer.
// Imported by the per-bit stage and the top level.
package sw_debounce_pkg;

    typedef enum logic {
        SW_STABLE,
        SW_COUNTING
    } sw_state_e;

    localparam int SW_DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int SW_SYNC_STAGES = 2;

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bundle: raw pin levels in, debounced levels and edge pulses out.
// master = board/PIO side, slave = debouncer.
interface sw_debounce_if #(
    parameter int WIDTH = 4
) ();

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_any;

    modport master (
        output sw_raw,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  sw_any
    );

    modport slave (
        input  sw_raw,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output sw_any
    );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser, hold counter, 2-state FSM, edge pulses.
// Edge registers exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic [SW_SYNC_STAGES-1:0] sync_q;
    sw_state_e                 state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic                      db_q;
    logic                      s2;
    logic                      accept;

    assign s2 = sync_q[SW_SYNC_STAGES-1];

    // First differing cycle counts as 1, so acceptance lands D cycles after s2 moves
    assign cnt_d  = (state_q == SW_STABLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign accept = (s2 != db_q) && (cnt_d == LIMIT);

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= SW_STABLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
`ifdef SW_DEBOUNCE_EDGE_EN
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[SW_SYNC_STAGES-2:0], raw_i};
            unique case (1'b1)
                (s2 == db_q): begin
                    state_q <= SW_STABLE;
                    cnt_q   <= '0;
                end
                accept: begin
                    db_q    <= s2;
                    state_q <= SW_STABLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= SW_COUNTING;
                    cnt_q   <= cnt_d;
                end
            endcase
`ifdef SW_DEBOUNCE_EDGE_EN
            rise_q <= accept & s2;
            fall_q <= accept & ~s2;
`endif
        end
    end

    assign db_o = db_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch debouncer top: WIDTH independent bit stages plus sw_any.
// Optional edge pulses: define SW_DEBOUNCE_EDGE_EN.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20
) (
    input  logic         clk,
    input  logic         reset,
    sw_debounce_if.slave bus
);

    // Counter must hold DEBOUNCE_CYCLES without wrapping
    if (DEBOUNCE_CYCLES < 1 ||
        64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cfg
        $error("sw_debounce: need 1 <= DEBOUNCE_CYCLES < 2**CNT_W");
    end

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .raw_i (bus.sw_raw[i]),
            .db_o  (db[i]),
            .rise_o(rise[i]),
            .fall_o(fall[i])
        );
    end

    assign bus.sw_db   = db;
    assign bus.sw_rise = rise;
    assign bus.sw_fall = fall;
    assign bus.sw_any  = |{rise, fall};

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (DEBOUNCE_CYCLES=4, CNT_W=3, WIDTH=4).
// Works with or without SW_DEBOUNCE_EDGE_EN.
module tb_sw_debounce;

    localparam int W = 4;
    localparam int D = 4;

`ifdef SW_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk;
    logic reset;

    sw_debounce_if #(.WIDTH(W)) bus ();

    sw_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: 2-stage delay, then a bit flips once its last D
    // synchronised samples all disagree with the current debounced level.
    logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
    logic [W-1:0] m_hist[$];

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
        m_hist = {};
        for (int k = 0; k < D; k++) m_hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [W-1:0] drop;
        bit all;
        if (reset) begin
            model_clear();
            return;
        end
        m_hist.push_back(m_s2);
        drop = m_hist.pop_front();
        m_rise = '0;
        m_fall = '0;
        for (int b = 0; b < W; b++) begin
            all = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][b] == m_db[b]) all = 1'b0;
            if (all) begin
                m_db[b] = ~m_db[b];
                if (m_db[b]) m_rise[b] = 1'b1;
                else         m_fall[b] = 1'b1;
            end
        end
        if (!EDGE) begin
            m_rise = '0;
            m_fall = '0;
        end
        m_s2 = m_s1;
        m_s1 = bus.sw_raw;
    endtask

    task automatic check(input string name, input logic [W-1:0] db,
                         input logic [W-1:0] ri, input logic [W-1:0] fa);
        logic [W-1:0] er, ef;
        logic [3*W:0] act, exp;
        er  = EDGE ? ri : '0;
        ef  = EDGE ? fa : '0;
        act = {bus.sw_db, bus.sw_rise, bus.sw_fall, bus.sw_any};
        exp = {db, er, ef, |{er, ef}};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got db/rise/fall/any=%h/%h/%h/%b want %h/%h/%h/%b",
                     name, bus.sw_db, bus.sw_rise, bus.sw_fall, bus.sw_any,
                     db, er, ef, |{er, ef});
        end
    endtask

    // One clock: update model at the edge, compare #1 later
    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        #1;
        check(name, m_db, m_rise, m_fall);
    endtask

    task automatic do_reset(input logic [W-1:0] raw);
        @(negedge clk);
        bus.sw_raw = raw;
        reset = 1'b1;
        model_clear();
        #1;
        check("reset_async", '0, '0, '0);
        step("reset_held");
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    vec_t vt[25];

    initial begin
        vt = '{
            '{4'b0101, 4'h0, 4'h0, 4'h0}, '{4'b0101, 4'h0, 4'h0, 4'h0},
            '{4'b0101, 4'h0, 4'h0, 4'h0}, '{4'b0001, 4'h0, 4'h0, 4'h0},
            '{4'b0001, 4'h0, 4'h0, 4'h0}, '{4'b0001, 4'h1, 4'h1, 4'h0},
            '{4'b0001, 4'h1, 4'h0, 4'h0}, '{4'b1000, 4'h1, 4'h0, 4'h0},
            '{4'b1000, 4'h1, 4'h0, 4'h0}, '{4'b1000, 4'h1, 4'h0, 4'h0},
            '{4'b1000, 4'h1, 4'h0, 4'h0}, '{4'b1000, 4'h1, 4'h0, 4'h0},
            '{4'b1000, 4'h8, 4'h8, 4'h1}, '{4'b1000, 4'h8, 4'h0, 4'h0},
            '{4'b1010, 4'h8, 4'h0, 4'h0}, '{4'b1000, 4'h8, 4'h0, 4'h0},
            '{4'b1010, 4'h8, 4'h0, 4'h0}, '{4'b1000, 4'h8, 4'h0, 4'h0},
            '{4'b1010, 4'h8, 4'h0, 4'h0}, '{4'b1010, 4'h8, 4'h0, 4'h0},
            '{4'b1010, 4'h8, 4'h0, 4'h0}, '{4'b1010, 4'h8, 4'h0, 4'h0},
            '{4'b1010, 4'h8, 4'h0, 4'h0}, '{4'b1010, 4'hA, 4'h2, 4'h0},
            '{4'b1010, 4'hA, 4'h0, 4'h0}
        };

        reset = 1'b0;
        bus.sw_raw = '0;
        model_clear();

        // Reset with all switches high, then full-latency re-acceptance
        do_reset(4'hF);
        for (int k = 1; k <= 7; k++) begin
            step("rst_model");
            if (k == 6)      check("rst_accept", 4'hF, 4'hF, 4'h0);
            else if (k == 7) check("rst_after", 4'hF, 4'h0, 4'h0);
            else             check("rst_wait", 4'h0, 4'h0, 4'h0);
        end

        // Clean flip, short glitch, simultaneous events, bounce
        do_reset(4'h0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            bus.sw_raw = vt[i].raw;
            step("vec_model");
            check($sformatf("vec%0d", i), vt[i].db, vt[i].rise, vt[i].fall);
        end

        // Reset two cycles into a bit-0 rise count
        do_reset(4'h0);
        @(negedge clk);
        bus.sw_raw = 4'b0001;
        for (int k = 0; k < 4; k++) step("mid_pre");
        check("mid_pre_db", 4'h0, 4'h0, 4'h0);
        do_reset(4'b0001);
        for (int k = 1; k <= 7; k++) begin
            step("mid_model");
            if (k == 6)      check("mid_accept", 4'h1, 4'h1, 4'h0);
            else if (k == 7) check("mid_after", 4'h1, 4'h0, 4'h0);
            else             check("mid_wait", 4'h0, 4'h0, 4'h0);
        end

        // Random: sparse flips so many levels survive the hold window
        do_reset(4'h0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < W; b++)
                if ($urandom_range(5) == 0) bus.sw_raw[b] = ~bus.sw_raw[b];
            if (c == 1500) begin
                reset = 1'b1;
                model_clear();
            end else if (c == 1503) begin
                reset = 1'b0;
            end
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
